// File: rtl/ce_switch_debouncer.sv
// Per-bit switch debouncer: two-flop synchronizer plus a small FSM per bit
// that accepts a new level after a run of stable clock-enable ticks.
module ce_switch_debouncer #(
    parameter int par_width        = 4,
    parameter int par_stable_ticks = 20
) (
    input  logic                 i_clk_mhz,
    input  logic                 i_rst_mhz,
    input  logic                 i_ce_div,
    input  logic [par_width-1:0] i_sw,
    output logic [par_width-1:0] o_sw_deb,
    output logic [par_width-1:0] o_sw_rise,
    output logic [par_width-1:0] o_sw_fall
);

    localparam int c_cnt_w = $clog2(par_stable_ticks + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(par_stable_ticks - 1);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_RISE_WAIT,
        ST_HIGH,
        ST_FALL_WAIT
    } state_t;

    logic [par_width-1:0] sync1_q;
    logic [par_width-1:0] s_sw_sync;

    state_t             st_q  [par_width];
    state_t             st_d  [par_width];
    logic [c_cnt_w-1:0] cnt_q [par_width];
    logic [c_cnt_w-1:0] cnt_d [par_width];

    logic [par_width-1:0] deb_q, deb_d;
    logic [par_width-1:0] rise_q, rise_d;
    logic [par_width-1:0] fall_q, fall_d;

    always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
        if (i_rst_mhz) begin
            sync1_q   <= '0;
            s_sw_sync <= '0;
            deb_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            for (int i = 0; i < par_width; i++) begin
                st_q[i]  <= ST_LOW;
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= i_sw;
            s_sw_sync <= sync1_q;
            deb_q     <= deb_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            for (int i = 0; i < par_width; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A bounce back to the old level wins over a coincident tick.
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < par_width; i++) begin
            unique case (st_q[i])
                ST_LOW: begin
                    if (s_sw_sync[i]) begin
                        st_d[i]  = ST_RISE_WAIT;
                        cnt_d[i] = '0;
                    end
                end
                ST_RISE_WAIT: begin
                    if (!s_sw_sync[i]) begin
                        st_d[i]  = ST_LOW;
                        cnt_d[i] = '0;
                    end else if (i_ce_div) begin
                        if (cnt_q[i] == c_cnt_max) begin
                            st_d[i]   = ST_HIGH;
                            cnt_d[i]  = '0;
                            deb_d[i]  = 1'b1;
                            rise_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + c_cnt_w'(1);
                        end
                    end
                end
                ST_HIGH: begin
                    if (!s_sw_sync[i]) begin
                        st_d[i]  = ST_FALL_WAIT;
                        cnt_d[i] = '0;
                    end
                end
                ST_FALL_WAIT: begin
                    if (s_sw_sync[i]) begin
                        st_d[i]  = ST_HIGH;
                        cnt_d[i] = '0;
                    end else if (i_ce_div) begin
                        if (cnt_q[i] == c_cnt_max) begin
                            st_d[i]   = ST_LOW;
                            cnt_d[i]  = '0;
                            deb_d[i]  = 1'b0;
                            fall_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + c_cnt_w'(1);
                        end
                    end
                end
                default: begin
                    st_d[i]  = ST_LOW;
                    cnt_d[i] = '0;
                end
            endcase
        end
    end

    assign o_sw_deb  = deb_q;
    assign o_sw_rise = rise_q;
    assign o_sw_fall = fall_q;

endmodule

// File: tb/tb_ce_switch_debouncer.sv
// Directed bench for ce_switch_debouncer: 2 bits, 4 stable ticks,
// clock-enable every 10 clocks unless tied low or high.
module tb_ce_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic [1:0] sw  = 2'b00;
    logic [1:0] deb, rise, fall;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;
    int rise_cnt [2];
    int fall_cnt [2];
    int both_cnt = 0;

    ce_switch_debouncer #(
        .par_width       (2),
        .par_stable_ticks(4)
    ) dut (
        .i_clk_mhz(clk),
        .i_rst_mhz(rst),
        .i_ce_div (ce),
        .i_sw     (sw),
        .o_sw_deb (deb),
        .o_sw_rise(rise),
        .o_sw_fall(fall)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            case (mode)
                0:       ce = (cyc % 10 == 0);
                1:       ce = 1'b0;
                default: ce = 1'b1;
            endcase
            for (int b = 0; b < 2; b++) begin
                rise_cnt[b] += int'(rise[b]);
                fall_cnt[b] += int'(fall[b]);
                if (rise[b] && fall[b]) both_cnt++;
            end
        end
    endtask

    task automatic align(input int ph);
        while (cyc % 10 != ph) step(1);
    endtask

    task automatic clr();
        for (int b = 0; b < 2; b++) begin
            rise_cnt[b] = 0;
            fall_cnt[b] = 0;
        end
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if ({deb, rise, fall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs got %b want 000000", {deb, rise, fall});
        end
        rst = 1'b0;
        clr();
        step(100);
        checks++;
        if (deb !== 2'b00) begin
            errors++;
            $display("FAIL idle_deb got %b want 00", deb);
        end
        checks++;
        if (rise_cnt[0] + rise_cnt[1] + fall_cnt[0] + fall_cnt[1] != 0) begin
            errors++;
            $display("FAIL idle_pulses got %0d want 0",
                     rise_cnt[0] + rise_cnt[1] + fall_cnt[0] + fall_cnt[1]);
        end
    endtask

    task automatic test_rise();
        align(5);
        sw = 2'b01;
        clr();
        step(35);
        checks++;
        if (deb !== 2'b00 || rise_cnt[0] != 0) begin
            errors++;
            $display("FAIL rise_early got deb %b rises %0d want 00 0", deb, rise_cnt[0]);
        end
        step(1);
        checks++;
        if ({deb, rise, fall} !== 6'b01_01_00) begin
            errors++;
            $display("FAIL rise_accept got %b want 010100", {deb, rise, fall});
        end
        step(1);
        checks++;
        if ({deb, rise} !== 4'b01_00) begin
            errors++;
            $display("FAIL rise_onecycle got %b want 0100", {deb, rise});
        end
        checks++;
        if (rise_cnt[0] != 1 || rise_cnt[1] != 0) begin
            errors++;
            $display("FAIL rise_count got %0d %0d want 1 0", rise_cnt[0], rise_cnt[1]);
        end
    endtask

    task automatic test_glitch();
        clr();
        for (int g = 0; g < 4; g++) begin
            sw = 2'b00;
            step(15);
            sw = 2'b01;
            step(15);
        end
        step(50);
        checks++;
        if (deb !== 2'b01) begin
            errors++;
            $display("FAIL glitch_deb got %b want 01", deb);
        end
        checks++;
        if (fall_cnt[0] != 0 || rise_cnt[0] != 0) begin
            errors++;
            $display("FAIL glitch_pulses got f%0d r%0d want f0 r0", fall_cnt[0], rise_cnt[0]);
        end
    endtask

    task automatic test_back_to_back();
        align(5);
        sw = 2'b11;
        clr();
        step(33);
        sw = 2'b01;
        step(3);
        checks++;
        if ({deb, rise} !== 4'b01_00) begin
            errors++;
            $display("FAIL bounce_tick got %b want 0100", {deb, rise});
        end
        align(5);
        checks++;
        if (rise_cnt[1] != 0) begin
            errors++;
            $display("FAIL bounce_norise got %0d want 0", rise_cnt[1]);
        end
        sw = 2'b11;
        step(35);
        checks++;
        if (deb !== 2'b01) begin
            errors++;
            $display("FAIL rehold_early got %b want 01", deb);
        end
        step(1);
        checks++;
        if ({deb, rise, fall} !== 6'b11_10_00) begin
            errors++;
            $display("FAIL rehold_accept got %b want 111000", {deb, rise, fall});
        end
    endtask

    task automatic test_ce_tied();
        align(5);
        sw = 2'b00;
        clr();
        step(35);
        checks++;
        if (deb !== 2'b11) begin
            errors++;
            $display("FAIL fall_early got %b want 11", deb);
        end
        step(1);
        checks++;
        if ({deb, rise, fall} !== 6'b00_00_11) begin
            errors++;
            $display("FAIL fall_both got %b want 000011", {deb, rise, fall});
        end
        mode = 1;
        ce   = 1'b0;
        sw   = 2'b11;
        clr();
        step(1000);
        checks++;
        if (deb !== 2'b00 || rise_cnt[0] + rise_cnt[1] != 0) begin
            errors++;
            $display("FAIL ce_low got deb %b rises %0d want 00 0", deb, rise_cnt[0] + rise_cnt[1]);
        end
        mode = 2;
        ce   = 1'b1;
        step(3);
        checks++;
        if (deb !== 2'b00) begin
            errors++;
            $display("FAIL ce_high_early got %b want 00", deb);
        end
        step(1);
        checks++;
        if ({deb, rise} !== 4'b11_11) begin
            errors++;
            $display("FAIL ce_high_accept got %b want 1111", {deb, rise});
        end
    endtask

    task automatic test_async_reset();
        sw = 2'b10;
        step(10);
        checks++;
        if (deb !== 2'b10) begin
            errors++;
            $display("FAIL pre_rst_deb got %b want 10", deb);
        end
        mode = 1;
        ce   = 1'b0;
        sw   = 2'b11;
        step(5);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({deb, rise, fall} !== 6'b0) begin
            errors++;
            $display("FAIL async_clear got %b want 000000", {deb, rise, fall});
        end
        step(2);
        checks++;
        if ({deb, rise, fall} !== 6'b0) begin
            errors++;
            $display("FAIL rst_held got %b want 000000", {deb, rise, fall});
        end
        rst  = 1'b0;
        mode = 2;
        ce   = 1'b1;
        clr();
        step(6);
        checks++;
        if (deb !== 2'b00 || rise_cnt[0] + rise_cnt[1] != 0) begin
            errors++;
            $display("FAIL post_rst_early got deb %b rises %0d want 00 0",
                     deb, rise_cnt[0] + rise_cnt[1]);
        end
        step(1);
        checks++;
        if ({deb, rise, fall} !== 6'b11_11_00) begin
            errors++;
            $display("FAIL post_rst_accept got %b want 111100", {deb, rise, fall});
        end
        step(2);
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL rise_fall_overlap got %0d want 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_back_to_back();
        test_ce_tied();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
